// File: rtl/weight_fifo_loader_if.sv
// Load-side bundle of the weight FIFO loader: start/status, weight-memory read
// port and column FIFO push/pop strobes.
interface weight_fifo_loader_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rd_data;
    logic              push_col0;
    logic              push_col1;
    logic              push_col2;
    logic [7:0]        data_out;
    logic              pop;
    logic              load_mmu;

    modport master (
        input  start, base_addr, mem_rd_data,
        output busy, done, mem_rd_en, mem_addr,
               push_col0, push_col1, push_col2, data_out, pop, load_mmu
    );

    modport slave (
        output start, base_addr, mem_rd_data,
        input  busy, done, mem_rd_en, mem_addr,
               push_col0, push_col1, push_col2, data_out, pop, load_mmu
    );
endinterface

// File: rtl/weight_fifo_loader.sv
// Fetches one 3-column weight tile (column-major) from memory, pushes it into
// the column weight FIFO, then pops it into the MMU with a 2-cycle skew drain.
module weight_fifo_loader #(
    parameter int ROWS   = 3,
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    weight_fifo_loader_if.master  bus
);
    localparam int TOTAL = 3 * ROWS;
    localparam int CNT_W = $clog2(TOTAL);
    localparam logic [CNT_W-1:0] LAST_K    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] LAST_POP  = CNT_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] LAST_SKEW = CNT_W'(1);
    localparam logic [1:0]       LAST_ROW  = 2'(ROWS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        FLUSH,
        POP,
        SKEW,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        row_q, row_d;
    logic [1:0]        col_q, col_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              push_vld_q;
    logic [1:0]        push_col_q;
    logic              rd_en;
    logic              pop_en;
    logic              load_en;
    logic              done_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        base_d  = base_q;
        rd_en   = 1'b0;
        pop_en  = 1'b0;
        load_en = 1'b0;
        done_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = FETCH;
                    cnt_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                    base_d  = bus.base_addr;
                end
            end
            FETCH: begin
                rd_en = 1'b1;
                if (cnt_q == LAST_K) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                // row/col track the byte being read so its push lands on the right column
                if (row_q == LAST_ROW) begin
                    row_d = '0;
                    col_d = col_q + 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            FLUSH: begin
                state_d = POP;
                cnt_d   = '0;
            end
            POP: begin
                pop_en  = 1'b1;
                load_en = 1'b1;
                if (cnt_q == LAST_POP) begin
                    state_d = SKEW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SKEW: begin
                load_en = 1'b1;
                if (cnt_q == LAST_SKEW) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                done_en = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read data returns one cycle after the strobe, so the push is a delayed copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            push_vld_q <= 1'b0;
            push_col_q <= '0;
        end else begin
            push_vld_q <= rd_en;
            push_col_q <= col_q;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_en;
    assign bus.mem_rd_en = rd_en;
    assign bus.mem_addr  = rd_en ? (base_q + ADDR_W'(cnt_q)) : '0;
    assign bus.push_col0 = push_vld_q && (push_col_q == 2'd0);
    assign bus.push_col1 = push_vld_q && (push_col_q == 2'd1);
    assign bus.push_col2 = push_vld_q && (push_col_q == 2'd2);
    assign bus.data_out  = push_vld_q ? bus.mem_rd_data : '0;
    assign bus.pop       = pop_en;
    assign bus.load_mmu  = load_en;
endmodule

// File: tb/tb_weight_fifo_loader.sv
// Directed bench for weight_fifo_loader: per-cycle output vectors against a
// timing table, plus a small column-FIFO model for the closed-loop view.
module tb_weight_fifo_loader;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    weight_fifo_loader_if #(.ADDR_W(8)) bus ();

    weight_fifo_loader #(.ROWS(3), .ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mem [256];
    logic [7:0] rd_log [$];
    logic [7:0] wrap_tbl [9] = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00,
                                 8'h01, 8'h02, 8'h03, 8'h04};

    always @(posedge clk) bus.mem_rd_data <= bus.mem_rd_en ? mem[bus.mem_addr] : 8'h00;

    // column FIFO model: col0 direct, col1 one register of skew, col2 two
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];
    logic [7:0] col0_out, r1, r2a, r2b;

    assign col0_out = (bus.pop && q0.size() != 0) ? q0[0] : 8'h00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q0.delete(); q1.delete(); q2.delete();
            r1 <= 8'h00; r2a <= 8'h00; r2b <= 8'h00;
        end else begin
            r1  <= (bus.pop && q1.size() != 0) ? q1[0] : 8'h00;
            r2a <= (bus.pop && q2.size() != 0) ? q2[0] : 8'h00;
            r2b <= r2a;
            if (bus.pop) begin
                if (q0.size() != 0) void'(q0.pop_front());
                if (q1.size() != 0) void'(q1.pop_front());
                if (q2.size() != 0) void'(q2.pop_front());
            end
            if (bus.push_col0) q0.push_back(bus.data_out);
            if (bus.push_col1) q1.push_back(bus.data_out);
            if (bus.push_col2) q2.push_back(bus.data_out);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return {8'h00, bus.busy, bus.done, bus.mem_rd_en, bus.mem_addr,
                bus.push_col2, bus.push_col1, bus.push_col0, bus.data_out,
                bus.pop, bus.load_mmu};
    endfunction

    // n = cycles after the accepting edge T; ROWS=3 timing table
    function automatic logic [31:0] expv(input logic [7:0] base, input int n);
        logic       busy, done, rd, push, pop, load;
        logic [7:0] addr, data, a;
        logic [2:0] pv;
        busy = (n >= 1 && n <= 16);
        done = (n == 16);
        rd   = (n >= 1 && n <= 9);
        a    = base + 8'(n - 1);
        addr = rd ? a : 8'h00;
        push = (n >= 2 && n <= 10);
        pv   = push ? (3'b001 << ((n - 2) / 3)) : 3'b000;
        a    = base + 8'(n - 2);
        data = push ? mem[a] : 8'h00;
        pop  = (n >= 11 && n <= 13);
        load = (n >= 11 && n <= 15);
        return {8'h00, busy, done, rd, addr, pv, data, pop, load};
    endfunction

    function automatic logic [31:0] expf(input logic [7:0] base, input int n);
        logic [7:0] c0, c1, c2, a;
        a  = base + 8'(n - 11);
        c0 = (n >= 11 && n <= 13) ? mem[a] : 8'h00;
        a  = base + 8'(3 + n - 12);
        c1 = (n >= 12 && n <= 14) ? mem[a] : 8'h00;
        a  = base + 8'(6 + n - 13);
        c2 = (n >= 13 && n <= 15) ? mem[a] : 8'h00;
        return {8'h00, c0, c1, c2};
    endfunction

    // Caller raises start (with base_addr) before calling; accepting edge is the next posedge.
    task automatic run_load(input logic [7:0] base, input int inj, input int rst_at,
                            input int nmax, input bit chain);
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.base_addr = ~base;
        for (int n = 1; n <= nmax; n++) begin
            @(negedge clk);
            check($sformatf("b%02h_cyc%0d", base, n), obs(), expv(base, n));
            check($sformatf("b%02h_fifo%0d", base, n), {8'h00, col0_out, r1, r2b}, expf(base, n));
            if (bus.mem_rd_en) rd_log.push_back(bus.mem_addr);
            bus.start = (n == inj) || (chain && n == nmax);
            if (n == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_async", obs(), 32'h0);
                break;
            end
        end
    endtask

    initial begin
        int nz;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i - 15);
        rst = 1'b1;
        bus.start = 1'b0;
        bus.base_addr = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset", obs(), 32'h0);
        rst = 1'b0;

        // basic: bytes 1..9 at 0x10
        @(negedge clk);
        bus.base_addr = 8'h10; bus.start = 1'b1;
        run_load(8'h10, 0, 0, 20, 1'b0);

        // address wrap
        rd_log.delete();
        bus.base_addr = 8'hFC; bus.start = 1'b1;
        run_load(8'hFC, 0, 0, 20, 1'b0);
        check("wrap_len", 32'(rd_log.size()), 32'd9);
        for (int i = 0; i < 9 && i < rd_log.size(); i++)
            check($sformatf("wrap_addr%0d", i), {24'h0, rd_log[i]}, {24'h0, wrap_tbl[i]});

        // start during a load is ignored
        bus.base_addr = 8'h20; bus.start = 1'b1;
        run_load(8'h20, 5, 0, 24, 1'b0);

        // back-to-back: second start in the idle cycle right after done
        bus.base_addr = 8'h30; bus.start = 1'b1;
        run_load(8'h30, 0, 0, 17, 1'b1);
        bus.base_addr = 8'h40;
        run_load(8'h40, 0, 0, 20, 1'b0);

        // reset mid-load, then a fresh load
        bus.base_addr = 8'h50; bus.start = 1'b1;
        run_load(8'h50, 0, 6, 20, 1'b0);
        repeat (2) begin
            @(negedge clk);
            check("rst_hold", obs(), 32'h0);
        end
        rst = 1'b0;
        nz = 0;
        repeat (20) begin
            @(negedge clk);
            if (obs() != 32'h0) nz++;
        end
        check("post_rst_quiet", 32'(nz), 32'd0);
        bus.base_addr = 8'h60; bus.start = 1'b1;
        run_load(8'h60, 0, 0, 20, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/weight_fifo_loader.md
WEIGHT_FIFO_LOADER -- requirements
Module: weight_fifo_loader

Interface
REQ-001 Parameter ROWS, default 3, weights per column pushed per load; legal range 1..4.
REQ-002 Parameter ADDR_W, default 8, weight-memory address width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to load one 3-column weight tile.
REQ-006 base_addr  input  ADDR_W  memory address of the tile's first byte; sampled when start is accepted.
REQ-007 busy  output  1  high while a load is in progress.
REQ-008 done  output  1  one-cycle pulse at the end of a load.
REQ-009 mem_rd_en  output  1  weight-memory read strobe.
REQ-010 mem_addr  output  ADDR_W  weight-memory read address.
REQ-011 mem_rd_data  input  8  read data, valid exactly one cycle after mem_rd_en.
REQ-012 push_col0, push_col1, push_col2  output  1 each  per-column push strobes into the column weight FIFO.
REQ-013 data_out  output  8  shared push data bus to all three columns.
REQ-014 pop  output  1  pop strobe to the column weight FIFO.
REQ-015 load_mmu  output  1  MMU weight-latch window, covering pop plus 2 skew-drain cycles.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, FLUSH, POP, SKEW, DONE.
REQ-017 In IDLE, start=1 SHALL be accepted at edge T: base_addr latched, counters cleared, state FETCH, busy=1 from T+1.
REQ-018 start while not IDLE SHALL be ignored; no queuing, no side effect.
REQ-019 FETCH SHALL last 3*ROWS cycles; in fetch cycle k (0..3*ROWS-1) mem_rd_en=1 and mem_addr=base_addr+k, modulo 2^ADDR_W.
REQ-020 Memory layout is column-major: byte k is column c=k/ROWS, row r=k%ROWS.
REQ-021 One cycle after each read, exactly one push_colc SHALL be 1, c being that byte's column, with data_out=mem_rd_data in the same cycle.
REQ-022 Pushes per column SHALL be in row order 0..ROWS-1; never two push strobes in one cycle.
REQ-023 FLUSH SHALL last 1 cycle, covering the final read's return push; mem_rd_en=0.
REQ-024 POP SHALL last ROWS cycles with pop=1 and load_mmu=1.
REQ-025 SKEW SHALL last 2 cycles with pop=0 and load_mmu=1, draining the col1/col2 skew registers.
REQ-026 DONE SHALL last 1 cycle: done=1, busy=1, load_mmu=0; next state IDLE, where busy=0.
REQ-027 ROWS=3 timing: reads T+1..T+9, pushes T+2..T+10, pop T+11..T+13, load_mmu T+11..T+15, done T+16.
REQ-028 A start in IDLE in the cycle after done SHALL be accepted normally, giving back-to-back loads.
REQ-029 Outside the cycles above, mem_rd_en, push_col*, pop, load_mmu and done SHALL be 0; data_out SHALL be 0 when no push is active.
REQ-030 Row/column counters SHALL be sized to hold 3*ROWS-1 without overflow; the address adder wraps silently.

Reset
REQ-031 rst=1 SHALL asynchronously force state IDLE, busy, done, mem_rd_en, push_col*, pop and load_mmu to 0; mem_addr and data_out to 0.
REQ-032 rst asserted mid-load SHALL abort the load: no further reads, pushes or pops, and no done pulse.
REQ-033 After rst deasserts, the first start SHALL be handled exactly as in REQ-017.

Verification
REQ-034 Basic load: base_addr=0x10, memory[0x10+k]=k+1, start -> pushes col0=1,2,3; col1=4,5,6; col2=7,8,9 at T+2..T+10; pop T+11..T+13; done T+16.
REQ-035 Address wrap: base_addr=0xFC -> mem_addr sequence FC,FD,FE,FF,00,01,02,03,04.
REQ-036 Busy start: start pulsed at T+5 during a load -> ignored; single done at T+16; no second read burst.
REQ-037 Back-to-back: second start in the cycle after done -> second read burst begins the next cycle; push order matches REQ-034.
REQ-038 Reset mid-load: rst at T+6 -> all outputs 0 immediately; no done; a fresh start then completes in 16 cycles.
REQ-039 Closed loop: loader connected to the column weight FIFO with memory bytes 1..9 -> col0_out=1,2,3 on pop cycles; col1_out and col2_out show the same sequence as their column values delayed 1 and 2 cycles, all within load_mmu.
